unified_mem: RTL and testbench
==============================

UNIFIED_MEM -- requirements
Module: unified_mem

Interface
REQ-001 Parameter DATA_W, default 32: data word width; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_W, default 9: word-address width.
REQ-003 Parameter DEPTH, default 512: implemented words; SHALL satisfy DEPTH <= 2**ADDR_W.
REQ-004 Parameter WAIT_CYC, default 0: extra wait cycles before each access, range 0..15.
REQ-005 Parameter INIT_FILE, default "" (empty): hex preload file; empty means no preload.
REQ-006 CLK  input  1: single clock, all state on rising edge.
REQ-007 RSTN  input  1: reset, asynchronous, active-low.
REQ-008 REQ  input  1: access request, sampled only in IDLE.
REQ-009 WE  input  DATA_W/8: byte write enables; nonzero = write, zero = read.
REQ-010 ADDR  input  ADDR_W: word address.
REQ-011 WD  input  DATA_W: write data.
REQ-012 IRWE  input  1: on a read request, also load the read word into IR.
REQ-013 RD  output  DATA_W: registered read data.
REQ-014 IR  output  DATA_W: instruction register.
REQ-015 READY  output  1: one-cycle completion pulse.
REQ-016 ERR  output  1: out-of-range flag, valid while READY=1.

Function
REQ-017 FSM states SHALL be IDLE, WAIT, RESP.
REQ-018 IDLE with REQ=1 at edge k: latch WE/ADDR/WD/IRWE, load counter with WAIT_CYC, go to WAIT; REQ=0: stay in IDLE.
REQ-019 WAIT, counter nonzero: decrement and stay; counter zero: perform the access at that edge, go to RESP.
REQ-020 RESP: READY=1 for exactly one cycle, then go to IDLE; REQ during WAIT or RESP SHALL be ignored and not queued.
REQ-021 Latency: READY high in the cycle after edge k+1+WAIT_CYC; minimum issue interval is WAIT_CYC+3 cycles.
REQ-022 Write: only bytes with WE[i]=1 updated (bits 8i+7..8i); other bytes unchanged; RD, IR hold.
REQ-023 Read: RD loads MEM[ADDR] at the access edge; when the latched IRWE=1, IR loads the same word at the same edge.
REQ-024 IR SHALL hold its value in every other cycle, including write requests issued with IRWE=1.
REQ-025 ADDR >= DEPTH: no memory change; on a read RD loads 0 and IR is unchanged; ERR=1 during RESP.
REQ-026 ERR=0 whenever READY=0 and for in-range accesses.
REQ-027 Request inputs SHALL affect the access only through the values latched at edge k.
REQ-028 Memory contents SHALL be loaded from INIT_FILE at elaboration when non-empty and are otherwise undefined.

Reset
REQ-029 RSTN=0 SHALL immediately force state IDLE, RD=0, IR=0, READY=0, ERR=0, counter=0.
REQ-030 Reset SHALL NOT clear memory contents.
REQ-031 Reset asserted before the access edge SHALL abort the request with no write performed.
REQ-032 Outputs SHALL stay at reset values until the first request completes after RSTN returns to 1.

Verification
REQ-033 WAIT_CYC=0: write WE=4'hF ADDR=20 WD=17, then read ADDR=20 -> READY at edge k+2, RD=17, ERR=0.
REQ-034 Byte merge: MEM[21]=32'hAABBCCDD, write WE=4'b0010 WD=32'h00001100 -> read returns 32'hAABB11DD.
REQ-035 WAIT_CYC=3: read with IRWE=1 of MEM[22]=32'hFFFFFFFB -> READY exactly 5 cycles after edge k; RD=IR=32'hFFFFFFFB.
REQ-036 Instruction-register hold:
- Sequence: read IRWE=1 (value 250), then read IRWE=0 (value 31), then write IRWE=1.
- Required: IR=250 throughout; RD=31 after the second read.
REQ-037 Out-of-range: DEPTH=256, read ADDR=300 -> RD=0, ERR=1 with READY; write ADDR=300 -> ERR=1, no memory change.
REQ-038 Reset mid-operation: WAIT_CYC=5, write issued, RSTN pulsed low in WAIT -> outputs immediately 0, target word unchanged; REQ held high during WAIT is ignored.

Source files
------------

// File: rtl/unified_mem.sv
// unified_mem: single-port word memory with byte write enables, a fixed
// number of wait cycles per access, a registered read port and an
// instruction register that can capture the word returned by a read.
//
// Ports:
//   CLK, RSTN      clock (rising edge), asynchronous active-low reset
//   REQ            access request, sampled only while idle
//   WE             byte write enables (nonzero = write, zero = read)
//   ADDR, WD       word address and write data
//   IRWE           on a read, also load the returned word into IR
//   RD             registered read data
//   IR             instruction register
//   READY          one-cycle completion pulse
//   ERR            address out of range, qualified by READY
module unified_mem #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 9,
  parameter int unsigned DEPTH     = 512,
  parameter int unsigned WAIT_CYC  = 0,
  parameter string       INIT_FILE = ""
) (
  input  logic                CLK,
  input  logic                RSTN,
  input  logic                REQ,
  input  logic [DATA_W/8-1:0] WE,
  input  logic [ADDR_W-1:0]   ADDR,
  input  logic [DATA_W-1:0]   WD,
  input  logic                IRWE,
  output logic [DATA_W-1:0]   RD,
  output logic [DATA_W-1:0]   IR,
  output logic                READY,
  output logic                ERR
);

  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [NB-1:0]     we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wd_q;
  logic              irwe_q;
  logic [DATA_W-1:0] rd_q;
  logic [DATA_W-1:0] ir_q;
  logic              ready_q;
  logic              err_q;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              in_range_c;
  logic              access_c;
  logic              write_c;
  logic [IDX_W-1:0]  idx_c;

  // Access happens on the edge that leaves WAIT with an exhausted counter.
  assign in_range_c = (32'(addr_q) < DEPTH);
  assign access_c   = (state_q == S_WAIT) && (cnt_q == '0);
  assign write_c    = access_c && (we_q != '0) && in_range_c;
  assign idx_c      = IDX_W'(addr_q);

  // Memory array: no reset so contents survive RSTN. An async reset forces
  // state_q to IDLE, which suppresses any pending write.
  always_ff @(posedge CLK) begin
    if (write_c) begin
      for (int i = 0; i < NB; i++) begin
        if (we_q[i]) mem[idx_c][8*i +: 8] <= wd_q[8*i +: 8];
      end
    end
  end

  // Request sequencing, read data, instruction register and status.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= '0;
      addr_q  <= '0;
      wd_q    <= '0;
      irwe_q  <= 1'b0;
      rd_q    <= '0;
      ir_q    <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (REQ) begin
            we_q    <= WE;
            addr_q  <= ADDR;
            wd_q    <= WD;
            irwe_q  <= IRWE;
            cnt_q   <= CNT_W'(WAIT_CYC);
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else begin
            state_q <= S_RESP;
            ready_q <= 1'b1;
            err_q   <= !in_range_c;
            // Reads update RD (zero when out of range); IR only on in-range reads.
            if (we_q == '0) begin
              rd_q <= in_range_c ? mem[idx_c] : '0;
              if (irwe_q && in_range_c) ir_q <= mem[idx_c];
            end
          end
        end
        S_RESP: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign RD    = rd_q;
  assign IR    = ir_q;
  assign READY = ready_q;
  assign ERR   = err_q;

endmodule

// File: tb/tb_unified_mem.sv
// Bench for unified_mem: three instances with different wait/depth settings,
// a table of directed accesses, hand-written reset/latency sequences and a
// randomized run compared against a word-array reference model.
`timescale 1ns/1ps
module tb_unified_mem;

  localparam int unsigned DW  = 32;
  localparam int unsigned AW  = 9;
  localparam int unsigned NB  = 4;
  localparam int unsigned NI  = 3;
  localparam int unsigned MW  = 512;
  localparam int unsigned TMO = 40;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rstn  [NI];
  logic          req   [NI];
  logic [NB-1:0] we    [NI];
  logic [AW-1:0] addr  [NI];
  logic [DW-1:0] wd    [NI];
  logic          irwe  [NI];
  logic [DW-1:0] rd    [NI];
  logic [DW-1:0] ir    [NI];
  logic          ready [NI];
  logic          err   [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    unified_mem #(
      .DATA_W   (DW),
      .ADDR_W   (AW),
      .DEPTH    ((g == 0) ? 256 : 512),
      .WAIT_CYC ((g == 0) ? 0 : ((g == 1) ? 3 : 5)),
      .INIT_FILE("")
    ) u_dut (
      .CLK  (clk),
      .RSTN (rstn[g]),
      .REQ  (req[g]),
      .WE   (we[g]),
      .ADDR (addr[g]),
      .WD   (wd[g]),
      .IRWE (irwe[g]),
      .RD   (rd[g]),
      .IR   (ir[g]),
      .READY(ready[g]),
      .ERR  (err[g])
    );
  end

  function automatic int unsigned wait_of(input int n);
    return (n == 0) ? 0 : ((n == 1) ? 3 : 5);
  endfunction

  function automatic int unsigned depth_of(input int n);
    return (n == 0) ? 256 : 512;
  endfunction

  // Reference model: memory words with a known-bit mask, plus RD/IR images.
  logic [DW-1:0] m_mem [NI][MW];
  logic [DW-1:0] m_kn  [NI][MW];
  logic [DW-1:0] m_rd  [NI];
  logic [DW-1:0] m_rdk [NI];
  logic [DW-1:0] m_ir  [NI];
  logic [DW-1:0] m_irk [NI];

  int total;
  int bad;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic model_reset(input int n);
    m_rd[n]  = '0;
    m_rdk[n] = '1;
    m_ir[n]  = '0;
    m_irk[n] = '1;
  endtask

  // One complete access on instance n; checks latency, pulse width, ERR and
  // RD/IR against the model, and returns what was seen with READY high.
  task automatic txn(input int n, input logic [NB-1:0] w, input logic [AW-1:0] a,
                     input logic [DW-1:0] d, input logic ie, input logic hold,
                     output logic [DW-1:0] o_rd, output logic [DW-1:0] o_ir,
                     output logic o_err);
    int unsigned cyc;
    bit          got;
    bit          inr;
    @(negedge clk);
    req[n]  = 1'b1;
    we[n]   = w;
    addr[n] = a;
    wd[n]   = d;
    irwe[n] = ie;
    @(posedge clk);
    #1;
    // Inputs after the request edge must not matter; REQ may stay high.
    req[n]  = hold;
    we[n]   = NB'($urandom);
    addr[n] = AW'($urandom);
    wd[n]   = DW'($urandom);
    irwe[n] = 1'($urandom);
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < TMO) begin
      @(negedge clk);
      cyc++;
      got = (ready[n] === 1'b1);
    end
    req[n] = 1'b0;
    o_rd  = rd[n];
    o_ir  = ir[n];
    o_err = err[n];
    chk($sformatf("latency u%0d a%0d", n, a), DW'(cyc), DW'(wait_of(n) + 2));

    inr = (int'(a) < int'(depth_of(n)));
    chk($sformatf("err u%0d a%0d", n, a), DW'(o_err), DW'(!inr));
    if (w != '0) begin
      if (inr) begin
        for (int b = 0; b < NB; b++) begin
          if (w[b]) begin
            m_mem[n][a][8*b +: 8] = d[8*b +: 8];
            m_kn[n][a][8*b +: 8]  = 8'hFF;
          end
        end
      end
    end else if (inr) begin
      m_rd[n]  = m_mem[n][a];
      m_rdk[n] = m_kn[n][a];
      if (ie) begin
        m_ir[n]  = m_mem[n][a];
        m_irk[n] = m_kn[n][a];
      end
    end else begin
      m_rd[n]  = '0;
      m_rdk[n] = '1;
    end
    chk($sformatf("rd u%0d a%0d", n, a), o_rd & m_rdk[n], m_rd[n] & m_rdk[n]);
    chk($sformatf("ir u%0d a%0d", n, a), o_ir & m_irk[n], m_ir[n] & m_irk[n]);

    @(negedge clk);
    chk($sformatf("ready_pulse u%0d", n), DW'(ready[n]), DW'(0));
    chk($sformatf("err_idle u%0d", n), DW'(err[n]), DW'(0));
  endtask

  typedef struct {
    logic [NB-1:0] we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
    logic          irwe;
    logic [DW-1:0] rd;
    logic [DW-1:0] ir;
    logic          err;
  } vec_t;

  localparam int NV = 17;
  vec_t tbl [NV];

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    logic [DW-1:0] g_rd;
    logic [DW-1:0] g_ir;
    logic          g_err;
    logic [NB-1:0] rw;
    logic [AW-1:0] ra;

    total = 0;
    bad   = 0;

    tbl[0]  = '{4'hF, 9'd20,  32'd17,        1'b0, 32'd0,        32'd0,        1'b0};
    tbl[1]  = '{4'h0, 9'd20,  32'd0,         1'b0, 32'd17,       32'd0,        1'b0};
    tbl[2]  = '{4'hF, 9'd21,  32'hAABBCCDD,  1'b0, 32'd17,       32'd0,        1'b0};
    tbl[3]  = '{4'h2, 9'd21,  32'h00001100,  1'b0, 32'd17,       32'd0,        1'b0};
    tbl[4]  = '{4'h0, 9'd21,  32'd0,         1'b0, 32'hAABB11DD, 32'd0,        1'b0};
    tbl[5]  = '{4'hF, 9'd22,  32'd250,       1'b0, 32'hAABB11DD, 32'd0,        1'b0};
    tbl[6]  = '{4'hF, 9'd23,  32'd31,        1'b0, 32'hAABB11DD, 32'd0,        1'b0};
    tbl[7]  = '{4'h0, 9'd22,  32'd0,         1'b1, 32'd250,      32'd250,      1'b0};
    tbl[8]  = '{4'h0, 9'd23,  32'd0,         1'b0, 32'd31,       32'd250,      1'b0};
    tbl[9]  = '{4'hF, 9'd24,  32'd99,        1'b1, 32'd31,       32'd250,      1'b0};
    tbl[10] = '{4'hF, 9'd44,  32'h44444444,  1'b0, 32'd31,       32'd250,      1'b0};
    tbl[11] = '{4'h0, 9'd300, 32'd0,         1'b1, 32'd0,        32'd250,      1'b1};
    tbl[12] = '{4'hF, 9'd300, 32'h55555555,  1'b1, 32'd0,        32'd250,      1'b1};
    tbl[13] = '{4'h0, 9'd44,  32'd0,         1'b0, 32'h44444444, 32'd250,      1'b0};
    tbl[14] = '{4'hF, 9'd255, 32'hCAFEF00D,  1'b0, 32'h44444444, 32'd250,      1'b0};
    tbl[15] = '{4'h0, 9'd255, 32'd0,         1'b1, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0};
    tbl[16] = '{4'h0, 9'd256, 32'd0,         1'b0, 32'd0,        32'hCAFEF00D, 1'b1};

    for (int n = 0; n < NI; n++) begin
      rstn[n] = 1'b0;
      req[n]  = 1'b0;
      we[n]   = '0;
      addr[n] = '0;
      wd[n]   = '0;
      irwe[n] = 1'b0;
      model_reset(n);
      for (int i = 0; i < MW; i++) begin
        m_mem[n][i] = '0;
        m_kn[n][i]  = '0;
      end
    end

    // Reset values on every instance.
    repeat (3) @(negedge clk);
    for (int n = 0; n < NI; n++) begin
      chk($sformatf("reset rd u%0d", n), rd[n], '0);
      chk($sformatf("reset ir u%0d", n), ir[n], '0);
      chk($sformatf("reset ready u%0d", n), DW'(ready[n]), DW'(0));
      chk($sformatf("reset err u%0d", n), DW'(err[n]), DW'(0));
      rstn[n] = 1'b1;
    end

    // Directed table on the zero-wait, 256-word instance.
    for (int v = 0; v < NV; v++) begin
      txn(0, tbl[v].we, tbl[v].addr, tbl[v].wd, tbl[v].irwe, 1'b0, g_rd, g_ir, g_err);
      chk($sformatf("tbl%0d rd", v), g_rd, tbl[v].rd);
      chk($sformatf("tbl%0d ir", v), g_ir, tbl[v].ir);
      chk($sformatf("tbl%0d err", v), DW'(g_err), DW'(tbl[v].err));
    end

    // Three wait cycles: read with IRWE lands in RD and IR five cycles after the request edge.
    txn(1, 4'hF, 9'd22, 32'hFFFFFFFB, 1'b0, 1'b0, g_rd, g_ir, g_err);
    txn(1, 4'h0, 9'd22, 32'd0, 1'b1, 1'b0, g_rd, g_ir, g_err);
    chk("wait3 rd", g_rd, 32'hFFFFFFFB);
    chk("wait3 ir", g_ir, 32'hFFFFFFFB);

    // Five wait cycles: reset during WAIT aborts the write and clears outputs at once.
    txn(2, 4'hF, 9'd30, 32'h12345678, 1'b0, 1'b0, g_rd, g_ir, g_err);
    txn(2, 4'h0, 9'd30, 32'd0, 1'b1, 1'b1, g_rd, g_ir, g_err);
    chk("pre_abort rd", g_rd, 32'h12345678);
    @(negedge clk);
    req[2]  = 1'b1;
    we[2]   = 4'hF;
    addr[2] = 9'd30;
    wd[2]   = 32'hDEADBEEF;
    irwe[2] = 1'b1;
    @(posedge clk);
    #1;
    repeat (2) @(negedge clk);
    rstn[2] = 1'b0;
    #1;
    chk("abort rd", rd[2], '0);
    chk("abort ir", ir[2], '0);
    chk("abort ready", DW'(ready[2]), DW'(0));
    chk("abort err", DW'(err[2]), DW'(0));
    repeat (2) @(negedge clk);
    rstn[2] = 1'b1;
    req[2]  = 1'b0;
    model_reset(2);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk($sformatf("post_abort ready c%0d", c), DW'(ready[2]), DW'(0));
    end
    chk("post_abort rd hold", rd[2], '0);
    txn(2, 4'h0, 9'd30, 32'd0, 1'b0, 1'b0, g_rd, g_ir, g_err);
    chk("abort target kept", g_rd, 32'h12345678);
    chk("abort ir untouched", g_ir, '0);

    // Randomized accesses on every instance against the model.
    for (int n = 0; n < NI; n++) begin
      for (int t = 0; t < 50; t++) begin
        rw = ($urandom_range(0, 1) == 0) ? 4'h0 : NB'($urandom);
        ra = (n == 0) ? AW'($urandom_range(240, 275)) : AW'($urandom_range(16, 47));
        txn(n, rw, ra, DW'($urandom), 1'($urandom), 1'($urandom), g_rd, g_ir, g_err);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
